// File: rtl/neur_mac_accum.sv
// Multi-beat MAC accumulator: eight signed 17x17 products per beat, summed in pairs
// into four wrapping 32-bit lane accumulators behind a two-stage pipeline.
//
// state | meaning
// IDLE  | waiting for start_i; acc_o holds the last result
// RUN   | accepting beats until n_beats have been consumed
// DRAIN | last beat accepted; waiting for stage 1 to retire into acc_o
// DONE  | one-cycle completion pulse, then back to IDLE
module neur_mac_accum (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [2:0]   mode_i,
    input  logic [15:0]  n_beats_i,
    input  logic         beat_valid_i,
    output logic         beat_ready_o,
    output logic [1:0]   iteration_o,
    input  logic [135:0] weight_vals_i,
    input  logic [135:0] activations_i,
    output logic [127:0] acc_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [15:0]        n_q, n_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [1:0]         iter_q, iter_d;
    logic [3:0][31:0]   s1_q, s1_d;
    logic               s1_vld_q, s1_vld_d;
    logic [3:0][31:0]   acc_q, acc_d;

    logic               start_acc;
    logic               beat_acc;
    logic               last_beat;
    logic [1:0]         iter_last;
    logic signed [33:0] prod [8];
    logic signed [34:0] psum [4];
    logic signed [33:0] w_ext;
    logic signed [33:0] a_ext;
    logic [12:0]        unused_bits;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign beat_acc  = (state_q == ST_RUN) && beat_valid_i;
    assign last_beat = beat_acc && (cnt_q == n_q - 16'd1);

    // Mode 11 shares the single-pass schedule; its packed fields are unpacked by software.
    always_comb begin
        case (mode_q)
            2'b00:   iter_last = 2'd3;
            2'b10:   iter_last = 2'd1;
            default: iter_last = 2'd0;
        endcase
    end

    always_comb begin
        w_ext = '0;
        a_ext = '0;
        for (int k = 0; k < 8; k++) begin
            w_ext   = 34'($signed(weight_vals_i[k*17 +: 17]));
            a_ext   = 34'($signed(activations_i[k*17 +: 17]));
            prod[k] = w_ext * a_ext;
        end
        for (int j = 0; j < 4; j++) begin
            psum[j] = 35'(prod[2*j]) + 35'(prod[2*j+1]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (n_beats_i == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        s1_d     = s1_q;
        s1_vld_d = beat_acc;
        acc_d    = acc_q;

        if (s1_vld_q) begin
            for (int j = 0; j < 4; j++) begin
                acc_d[j] = acc_q[j] + s1_q[j];
            end
        end

        if (beat_acc) begin
            cnt_d  = cnt_q + 16'd1;
            iter_d = (iter_q == iter_last) ? 2'd0 : iter_q + 2'd1;
            for (int j = 0; j < 4; j++) begin
                s1_d[j] = psum[j][31:0];
            end
        end

        if (start_acc) begin
            mode_d = mode_i[1:0];
            n_d    = n_beats_i;
            cnt_d  = '0;
            iter_d = '0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            iter_q   <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            iter_q   <= iter_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            acc_q    <= acc_d;
        end
    end

    // Pair sums are kept to 32 bits because accumulation wraps; mode_i[2] has no meaning here.
    assign unused_bits = {mode_i[2], psum[3][34:32], psum[2][34:32],
                          psum[1][34:32], psum[0][34:32]};

    assign beat_ready_o = (state_q == ST_RUN);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign iteration_o  = iter_q;
    assign acc_o        = acc_q;

endmodule

// File: tb/tb_neur_mac_accum.sv
// Bench for neur_mac_accum: fixed vector table, reset/start corner sequences, and
// random operations checked against an arithmetic model of the lane sums.
module tb_neur_mac_accum;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   mode_i = '0;
    logic [15:0]  n_beats_i = '0;
    logic         beat_valid_i = 1'b0;
    logic         beat_ready_o;
    logic [1:0]   iteration_o;
    logic [135:0] weight_vals_i = '0;
    logic [135:0] activations_i = '0;
    logic [127:0] acc_o;
    logic         busy_o;
    logic         done_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int beat_cnt = 0;

    logic [135:0] w_q[$];
    logic [135:0] a_q[$];

    typedef struct {
        logic [2:0]   mode;
        int           n;
        logic [16:0]  w;
        logic [16:0]  a;
        logic [7:0]   lanes;
        int           stall_beat;
        int           stall_len;
        bit           poke;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[7];

    neur_mac_accum dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .n_beats_i     (n_beats_i),
        .beat_valid_i  (beat_valid_i),
        .beat_ready_o  (beat_ready_o),
        .iteration_o   (iteration_o),
        .weight_vals_i (weight_vals_i),
        .activations_i (activations_i),
        .acc_o         (acc_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_o) done_cnt++;
            if (beat_valid_i && beat_ready_o) beat_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int iter_of(input logic [2:0] m);
        case (m[1:0])
            2'b00:   return 4;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] model_acc(input int n);
        longint       sum[4];
        logic [127:0] r;
        logic [135:0] wv;
        logic [135:0] av;
        logic [16:0]  wl;
        logic [16:0]  al;
        for (int j = 0; j < 4; j++) sum[j] = 0;
        for (int b = 0; b < n; b++) begin
            wv = w_q[b];
            av = a_q[b];
            for (int k = 0; k < 8; k++) begin
                wl = wv[k*17 +: 17];
                al = av[k*17 +: 17];
                sum[k/2] += longint'($signed(wl)) * longint'($signed(al));
            end
        end
        r = '0;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = sum[j][31:0];
        return r;
    endfunction

    task automatic fill_uniform(input int n, input logic [16:0] w, input logic [16:0] a,
                                input logic [7:0] lanes);
        logic [135:0] wv;
        logic [135:0] av;
        w_q.delete();
        a_q.delete();
        for (int b = 0; b < n; b++) begin
            wv = '0;
            av = '0;
            for (int k = 0; k < 8; k++) begin
                if (lanes[k]) begin
                    wv[k*17 +: 17] = w;
                    av[k*17 +: 17] = a;
                end
            end
            w_q.push_back(wv);
            a_q.push_back(av);
        end
    endtask

    task automatic fill_random(input int n);
        logic [135:0] wv;
        logic [135:0] av;
        w_q.delete();
        a_q.delete();
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 8; k++) begin
                wv[k*17 +: 17] = 17'($urandom);
                av[k*17 +: 17] = 17'($urandom);
            end
            w_q.push_back(wv);
            a_q.push_back(av);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] mode, input int n,
                          input int stall_pct, input int stall_beat, input int stall_len,
                          input bit poke, input logic [127:0] exp);
        int d0;
        int bc0;
        int b;
        int guard;
        int stall_left;
        int it_n;
        bit stalled;
        bit poked;
        bit accepted;
        d0 = done_cnt;
        bc0 = beat_cnt;
        it_n = iter_of(mode);
        stalled = 1'b0;
        poked = 1'b0;

        start_i = 1'b1;
        mode_i = mode;
        n_beats_i = 16'(n);
        tick();
        start_i = 1'b0;
        mode_i = 3'($urandom);
        n_beats_i = 16'($urandom);
        chk({tag, " acc cleared"}, acc_o, '0);

        if (n == 0) begin
            chk({tag, " done next cycle"}, 128'(done_o), 128'(1'b1));
            chk({tag, " ready in done"}, 128'(beat_ready_o), 128'(1'b0));
            tick();
            chk({tag, " done single"}, 128'(done_o), 128'(1'b0));
            chk({tag, " idle busy"}, 128'(busy_o), 128'(1'b0));
            chk({tag, " done pulses"}, 128'(done_cnt - d0), 128'(1));
            chk({tag, " beats accepted"}, 128'(beat_cnt - bc0), 128'(0));
            return;
        end

        chk({tag, " busy in run"}, 128'(busy_o), 128'(1'b1));
        b = 0;
        guard = 0;
        stall_left = 0;
        while (b < n && guard < 500) begin
            if (b == stall_beat && !stalled) begin
                stall_left = stall_len;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                stall_left--;
                beat_valid_i = 1'b0;
            end else begin
                beat_valid_i = ($urandom_range(99) >= stall_pct);
            end
            if (beat_valid_i) begin
                weight_vals_i = w_q[b];
                activations_i = a_q[b];
            end else begin
                weight_vals_i = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
                activations_i = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
            end
            if (poke && b == 1 && !poked) begin
                start_i = 1'b1;
                mode_i = 3'b000;
                n_beats_i = 16'd1;
                poked = 1'b1;
            end
            chk({tag, " iteration"}, 128'(iteration_o), 128'(b % it_n));
            chk({tag, " ready in run"}, 128'(beat_ready_o), 128'(1'b1));
            accepted = beat_valid_i && beat_ready_o;
            tick();
            start_i = 1'b0;
            if (accepted) b++;
            guard++;
        end
        if (b < n) chk({tag, " beats timeout"}, 128'(b), 128'(n));
        beat_valid_i = 1'b0;

        chk({tag, " ready after last"}, 128'(beat_ready_o), 128'(1'b0));
        chk({tag, " done early T+1"}, 128'(done_o), 128'(1'b0));
        tick();
        chk({tag, " acc at T+2"}, acc_o, exp);
        chk({tag, " done early T+2"}, 128'(done_o), 128'(1'b0));
        tick();
        chk({tag, " done at T+3"}, 128'(done_o), 128'(1'b1));
        tick();
        chk({tag, " done single"}, 128'(done_o), 128'(1'b0));
        chk({tag, " idle busy"}, 128'(busy_o), 128'(1'b0));
        chk({tag, " acc held"}, acc_o, exp);
        chk({tag, " done pulses"}, 128'(done_cnt - d0), 128'(1));
        chk({tag, " beats accepted"}, 128'(beat_cnt - bc0), 128'(n));
    endtask

    initial begin
        int d0;
        logic [2:0] rm;
        int rn;

        tbl[0] = '{3'b001, 3, 17'h00003, 17'h1FFFE, 8'hFF, -1, 0, 1'b0, {4{32'hFFFFFFDC}}};
        tbl[1] = '{3'b000, 5, 17'h00001, 17'h00001, 8'hFF,  3, 2, 1'b0, {4{32'h0000000A}}};
        tbl[2] = '{3'b000, 0, 17'h00005, 17'h00005, 8'hFF, -1, 0, 1'b0, 128'h0};
        tbl[3] = '{3'b010, 2, 17'h0FFFF, 17'h0FFFF, 8'h03, -1, 0, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'hFFF80004}};
        tbl[4] = '{3'b011, 1, 17'h1FFFF, 17'h10000, 8'hFF, -1, 0, 1'b0, {4{32'h00020000}}};
        tbl[5] = '{3'b110, 3, 17'h1FFFF, 17'h1FFFF, 8'h55, -1, 0, 1'b0, {4{32'h00000003}}};
        tbl[6] = '{3'b010, 4, 17'h00002, 17'h00005, 8'hFF, -1, 0, 1'b1, {4{32'h00000050}}};

        repeat (2) tick();
        chk("reset ready", 128'(beat_ready_o), 128'(1'b0));
        chk("reset busy", 128'(busy_o), 128'(1'b0));
        chk("reset done", 128'(done_o), 128'(1'b0));
        chk("reset iteration", 128'(iteration_o), 128'(0));
        chk("reset acc", acc_o, '0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            fill_uniform(tbl[i].n, tbl[i].w, tbl[i].a, tbl[i].lanes);
            run_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].n, 0,
                   tbl[i].stall_beat, tbl[i].stall_len, tbl[i].poke, tbl[i].exp);
        end

        start_i = 1'b1;
        mode_i = 3'b000;
        n_beats_i = 16'd10;
        tick();
        start_i = 1'b0;
        beat_valid_i = 1'b1;
        weight_vals_i = {8{17'd5}};
        activations_i = {8{17'd7}};
        repeat (3) tick();
        chk("pre-reset acc", acc_o, {4{32'd140}});
        chk("pre-reset iteration", 128'(iteration_o), 128'(3));
        d0 = done_cnt;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async reset ready", 128'(beat_ready_o), 128'(1'b0));
        chk("async reset busy", 128'(busy_o), 128'(1'b0));
        chk("async reset done", 128'(done_o), 128'(1'b0));
        chk("async reset iteration", 128'(iteration_o), 128'(0));
        chk("async reset acc", acc_o, '0);
        beat_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (6) tick();
        chk("no done after reset", 128'(done_cnt - d0), 128'(0));
        chk("idle after reset", 128'(busy_o), 128'(1'b0));
        fill_uniform(2, 17'h00004, 17'h1FFFD, 8'hFF);
        run_op("post-reset", 3'b001, 2, 0, -1, 0, 1'b0, {4{32'hFFFFFFD0}});

        for (int i = 0; i < 8; i++) begin
            rm = 3'($urandom);
            rn = $urandom_range(12, 1);
            fill_random(rn);
            run_op($sformatf("rand%0d", i), rm, rn, 25, -1, 0, 1'b0, model_acc(rn));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
